// File: rtl/pix_framer_pkg.sv
// Shared types and constants for the pixel line framer.
// Line length in bytes depends on whether PIX_FRAMER_CSUM_EN is defined.
package pix_framer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC_H,
        ST_SYNC_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_PIX_H,
        ST_PIX_L,
        ST_CSUM_H,
        ST_CSUM_L
    } framer_state_t;

    localparam logic [15:0] PAD_WORD  = 16'hFFFF;
    localparam int          HDR_BYTES = 4;
`ifdef PIX_FRAMER_CSUM_EN
    localparam int          TRL_BYTES = 2;
`else
    localparam int          TRL_BYTES = 0;
`endif

    function automatic int line_bytes(input int npix);
        return HDR_BYTES + TRL_BYTES + 2 * npix;
    endfunction

endpackage

// File: rtl/pix_queue.sv
// First-word-fall-through pixel queue: head visible on pop_dat while !empty.
// Push is ignored when full, pop when empty; flush empties it in one cycle.
module pix_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign pop_dat   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/pix_framer.sv
// Frames CCD lines into sync/line-number/pixel bytes for the TX FIFO; pads overrun lines to NPIX.
// PIX_FRAMER_CSUM_EN appends a 16-bit sum of the emitted pixel words after the pixels.
module pix_framer
    import pix_framer_pkg::*;
#(
    parameter int          NPIX      = 2048,
    parameter int          QDEPTH    = 4,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic        clk_160M,
    input  logic        nrst,
    input  logic        en,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_first,
    output logic        tx_wrreq,
    output logic [7:0]  tx_data,
    input  logic        tx_full,
    output logic [15:0] line_cnt,
    output logic        busy,
    output logic        overflow,
    output logic        sync_err
);

    localparam logic [15:0] NPIX_W   = 16'(NPIX);
    localparam logic [15:0] LAST_IDX = 16'(NPIX - 1);
`ifdef PIX_FRAMER_CSUM_EN
    localparam framer_state_t ST_AFTER_PIX = ST_CSUM_H;
`else
    localparam framer_state_t ST_AFTER_PIX = ST_IDLE;
`endif

    framer_state_t r_state;
    framer_state_t w_next;
    logic [15:0]   r_line_cnt;
    logic [15:0]   r_in_cnt;
    logic [15:0]   r_out_cnt;
    logic [7:0]    r_word_lo;
    logic          r_pad;
    logic          r_start_pend;
    logic          r_overflow;
    logic          r_sync_err;
`ifdef PIX_FRAMER_CSUM_EN
    logic [15:0]   r_csum;
`endif

    logic          w_q_full;
    logic          w_q_empty;
    logic [15:0]   w_q_dat;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_ready;
    logic          w_wr;
    logic          w_final;
    logic          w_start;
    logic          w_in_line;
    logic          w_acc;
    logic [15:0]   w_pix_word;
    logic [7:0]    w_byte;

    pix_queue #(.DEPTH(QDEPTH), .W(16)) u_queue (
        .clk      (clk_160M),
        .rst_n    (nrst),
        .push     (w_push),
        .push_dat (pix_data),
        .pop      (w_pop),
        .flush    (w_flush),
        .pop_dat  (w_q_dat),
        .full     (w_q_full),
        .empty    (w_q_empty)
    );

    assign w_pix_word = r_pad ? PAD_WORD : w_q_dat;

    always_comb begin
        w_byte  = 8'h00;
        w_ready = 1'b0;
        case (r_state)
            ST_SYNC_H: begin w_byte = SYNC_WORD[15:8];  w_ready = 1'b1; end
            ST_SYNC_L: begin w_byte = SYNC_WORD[7:0];   w_ready = 1'b1; end
            ST_CNT_H:  begin w_byte = r_line_cnt[15:8]; w_ready = 1'b1; end
            ST_CNT_L:  begin w_byte = r_line_cnt[7:0];  w_ready = 1'b1; end
            ST_PIX_H: begin
                w_ready = r_pad || !w_q_empty;
                if (w_ready) w_byte = w_pix_word[15:8];
            end
            ST_PIX_L:  begin w_byte = r_word_lo;        w_ready = 1'b1; end
`ifdef PIX_FRAMER_CSUM_EN
            ST_CSUM_H: begin w_byte = r_csum[15:8];     w_ready = 1'b1; end
            ST_CSUM_L: begin w_byte = r_csum[7:0];      w_ready = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_wr  = w_ready && !tx_full;
    assign w_pop = (r_state == ST_PIX_H) && w_wr && !r_pad;
`ifdef PIX_FRAMER_CSUM_EN
    assign w_final = (r_state == ST_CSUM_L) && w_wr;
`else
    assign w_final = (r_state == ST_PIX_L) && (r_out_cnt == LAST_IDX) && w_wr;
`endif

    // A line may start from IDLE or on the cycle its predecessor writes its last byte.
    assign w_start   = pix_valid && pix_first && en &&
                       (((r_state == ST_IDLE) && !r_start_pend) || w_final);
    assign w_in_line = ((r_state != ST_IDLE) || r_start_pend) && !w_final;
    assign w_acc     = pix_valid && w_in_line && !r_pad && (r_in_cnt != NPIX_W);
    assign w_push    = w_start || (w_acc && !w_q_full);
    assign w_flush   = w_acc && w_q_full;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start || r_start_pend) w_next = ST_SYNC_H;
            ST_SYNC_H: if (w_wr) w_next = ST_SYNC_L;
            ST_SYNC_L: if (w_wr) w_next = ST_CNT_H;
            ST_CNT_H:  if (w_wr) w_next = ST_CNT_L;
            ST_CNT_L:  if (w_wr) w_next = ST_PIX_H;
            ST_PIX_H:  if (w_wr) w_next = ST_PIX_L;
            ST_PIX_L:  if (w_wr) w_next = (r_out_cnt == LAST_IDX) ? ST_AFTER_PIX : ST_PIX_H;
`ifdef PIX_FRAMER_CSUM_EN
            ST_CSUM_H: if (w_wr) w_next = ST_CSUM_L;
            ST_CSUM_L: if (w_wr) w_next = ST_IDLE;
`endif
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_160M or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_line_cnt   <= 16'h0000;
            r_in_cnt     <= 16'h0000;
            r_out_cnt    <= 16'h0000;
            r_word_lo    <= 8'h00;
            r_pad        <= 1'b0;
            r_start_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
`ifdef PIX_FRAMER_CSUM_EN
            r_csum       <= 16'h0000;
`endif
        end else begin
            r_state      <= w_next;
            r_start_pend <= w_start && (r_state != ST_IDLE);

            if (w_start) begin
                r_in_cnt <= 16'd1;
                r_pad    <= 1'b0;
            end else if (w_push) begin
                r_in_cnt <= r_in_cnt + 16'd1;
            end else if (w_flush) begin
                r_pad      <= 1'b1;
                r_overflow <= 1'b1;
            end
            if (w_acc && pix_first) r_sync_err <= 1'b1;

            if ((r_state == ST_IDLE) && (w_next == ST_SYNC_H)) begin
                r_out_cnt <= 16'h0000;
`ifdef PIX_FRAMER_CSUM_EN
                r_csum    <= 16'h0000;
`endif
            end
            if ((r_state == ST_PIX_H) && w_wr) begin
                r_word_lo <= w_pix_word[7:0];
`ifdef PIX_FRAMER_CSUM_EN
                r_csum    <= r_csum + w_pix_word;
`endif
            end
            if ((r_state == ST_PIX_L) && w_wr) r_out_cnt <= r_out_cnt + 16'd1;
            if (w_final) r_line_cnt <= r_line_cnt + 16'd1;
        end
    end

    assign tx_wrreq = w_wr;
    assign tx_data  = w_byte;
    assign line_cnt = r_line_cnt;
    assign busy     = (r_state != ST_IDLE);
    assign overflow = r_overflow;
    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_pix_framer.sv
// Scoreboard bench for pix_framer with NPIX=4, QDEPTH=2; expected bytes are queued by stimulus.
`timescale 1ns/1ps
module tb_pix_framer;
    import pix_framer_pkg::*;

    localparam int NPIX   = 4;
    localparam int QDEPTH = 2;

    logic        clk_160M  = 1'b0;
    logic        nrst      = 1'b0;
    logic        en        = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data  = 16'h0000;
    logic        pix_first = 1'b0;
    logic        tx_full   = 1'b0;
    logic        tx_wrreq;
    logic [7:0]  tx_data;
    logic [15:0] line_cnt;
    logic        busy;
    logic        overflow;
    logic        sync_err;

    int          total  = 0;
    int          bad    = 0;
    int          wr_cnt = 0;
    int          base;
    int          k1;
    int          k2;
    logic [7:0]  mon_exp;
    logic [7:0]  exp_q[$];

    pix_framer #(.NPIX(NPIX), .QDEPTH(QDEPTH), .SYNC_WORD(16'hA55A)) dut (
        .clk_160M  (clk_160M),
        .nrst      (nrst),
        .en        (en),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_first (pix_first),
        .tx_wrreq  (tx_wrreq),
        .tx_data   (tx_data),
        .tx_full   (tx_full),
        .line_cnt  (line_cnt),
        .busy      (busy),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    always #5 clk_160M = ~clk_160M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted write pops one expected byte.
    always @(negedge clk_160M) begin
        if (nrst && tx_wrreq) begin
            wr_cnt++;
            check("wrreq_while_full", tx_full, 1'b0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got %02h expected none", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", tx_data, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk_160M);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic first, input int gap);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_first = first;
        tick();
        pix_valid = 1'b0;
        pix_first = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic exp_line(input logic [15:0] cnt, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w[4];
`ifdef PIX_FRAMER_CSUM_EN
        logic [15:0] s;
        s = 16'h0000;
`endif
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(cnt[15:8]);
        exp_q.push_back(cnt[7:0]);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[i][15:8]);
            exp_q.push_back(w[i][7:0]);
`ifdef PIX_FRAMER_CSUM_EN
            s = s + w[i];
`endif
        end
`ifdef PIX_FRAMER_CSUM_EN
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
`endif
    endtask

    task automatic wait_done(input string name, input int b);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check({name, "_in_time"}, (k < 300), 1'b1);
        check({name, "_nbytes"}, wr_cnt - b, line_bytes(NPIX));
        check({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        repeat (3) tick();
        check("rst_wrreq", tx_wrreq, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_line_cnt", line_cnt, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_sync_err", sync_err, 1'b0);
        nrst = 1'b1;
        en   = 1'b1;
        tick();

        // Basic line 0
        base = wr_cnt;
        exp_line(16'h0000, 16'h1234, 16'h0001, 16'hABCD, 16'h00FF);
        send(16'h1234, 1'b1, 5);
        send(16'h0001, 1'b0, 5);
        send(16'hABCD, 1'b0, 5);
        send(16'h00FF, 1'b0, 5);
        wait_done("line0", base);
        check("line0_cnt", line_cnt, 16'h0001);
        check("line0_overflow", overflow, 1'b0);
        check("line0_sync_err", sync_err, 1'b0);

        // TX FIFO stall during the low byte of the first pixel
        base = wr_cnt;
        exp_line(16'h0001, 16'hCAFE, 16'h0102, 16'h8000, 16'h7FFF);
        fork
            begin
                send(16'hCAFE, 1'b1, 5);
                send(16'h0102, 1'b0, 5);
                send(16'h8000, 1'b0, 5);
                send(16'h7FFF, 1'b0, 5);
            end
            begin
                k2 = 0;
                while (wr_cnt < base + 5 && k2 < 100) begin
                    @(negedge clk_160M);
                    #1;
                    k2++;
                end
                check("stall_reach", (k2 < 100), 1'b1);
                @(posedge clk_160M);
                #1;
                tx_full = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_160M);
                    check("stall_wrreq", tx_wrreq, 1'b0);
                    check("stall_data_hold", tx_data, 8'hFE);
                end
                @(posedge clk_160M);
                #1;
                tx_full = 1'b0;
            end
        join
        wait_done("stall", base);
        check("stall_cnt", line_cnt, 16'h0002);
        check("stall_overflow", overflow, 1'b0);

        // Overrun: queue of 2 fills while TX FIFO is full; line becomes all pads
        base = wr_cnt;
        exp_line(16'h0002, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        tx_full = 1'b1;
        send(16'h1111, 1'b1, 0);
        send(16'h2222, 1'b0, 0);
        send(16'h3333, 1'b0, 0);
        send(16'h4444, 1'b0, 3);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_busy", busy, 1'b1);
        tx_full = 1'b0;
        wait_done("ovf", base);
        check("ovf_cnt", line_cnt, 16'h0003);
        check("ovf_sync_err", sync_err, 1'b0);

        // Capture disabled: pix_first ignored
        en   = 1'b0;
        base = wr_cnt;
        send(16'h5555, 1'b1, 0);
        check("en0_busy_next", busy, 1'b0);
        repeat (6) tick();
        check("en0_busy", busy, 1'b0);
        check("en0_nwrites", wr_cnt - base, 0);

        // en dropped mid-line and a stray pix_first taken as an ordinary pixel
        en   = 1'b1;
        base = wr_cnt;
        exp_line(16'h0003, 16'h0F0F, 16'hF0F0, 16'h0000, 16'h8001);
        send(16'h0F0F, 1'b1, 3);
        en = 1'b0;
        send(16'hF0F0, 1'b1, 5);
        send(16'h0000, 1'b0, 5);
        send(16'h8001, 1'b0, 5);
        wait_done("entog", base);
        check("entog_cnt", line_cnt, 16'h0004);
        check("entog_sync_err", sync_err, 1'b1);
        en = 1'b1;

        // Reset while in PIX_L
        base = wr_cnt;
        exp_line(16'h0004, 16'h1357, 16'h2468, 16'h0000, 16'h0000);
        send(16'h1357, 1'b1, 0);
        k1 = 0;
        while (wr_cnt < base + 5 && k1 < 100) begin
            @(negedge clk_160M);
            #1;
            k1++;
        end
        check("rstmid_reach", (k1 < 100), 1'b1);
        @(posedge clk_160M);
        #1;
        check("rstmid_pre_wrreq", tx_wrreq, 1'b1);
        check("rstmid_pre_data", tx_data, 8'h57);
        nrst = 1'b0;
        exp_q.delete();
        #1;
        check("rstmid_wrreq", tx_wrreq, 1'b0);
        check("rstmid_data", tx_data, 8'h00);
        check("rstmid_line_cnt", line_cnt, 16'h0000);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_overflow", overflow, 1'b0);
        check("rstmid_sync_err", sync_err, 1'b0);
        repeat (2) tick();
        nrst = 1'b1;
        tick();

        base = wr_cnt;
        exp_line(16'h0000, 16'h4242, 16'h0000, 16'hFFFF, 16'h0001);
        send(16'h4242, 1'b1, 5);
        send(16'h0000, 1'b0, 5);
        send(16'hFFFF, 1'b0, 5);
        send(16'h0001, 1'b0, 5);
        wait_done("postrst", base);
        check("postrst_cnt", line_cnt, 16'h0001);

        // line_cnt wrap
        force dut.r_line_cnt = 16'hFFFF;
        tick();
        release dut.r_line_cnt;
        tick();
        check("wrap_preload", line_cnt, 16'hFFFF);
        base = wr_cnt;
        exp_line(16'hFFFF, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        send(16'h0102, 1'b1, 5);
        send(16'h0304, 1'b0, 5);
        send(16'h0506, 1'b0, 5);
        send(16'h0708, 1'b0, 5);
        wait_done("wrap", base);
        check("wrap_cnt", line_cnt, 16'h0000);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
